key_event_arb: RTL
==================

KEY_EVENT_ARB -- requirements
Module: key_event_arb

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, rate of the shared debounce strobe (10 ms period at defaults).
REQ-003 Parameter N_KEYS, default 4, number of debounced key sources; legal range 2..8.
REQ-004 Port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-006 Port key_cap_i  input  N_KEYS  one-cycle press pulses from the per-key debouncers, bit k = key k.
REQ-007 Port tick_o  output  1  one-cycle strobe every CLK_FREQ/TICK_HZ cycles, shared by all debouncers.
REQ-008 Port evt_valid_o  output  1  an event is offered on evt_id_o.
REQ-009 Port evt_ready_i  input  1  consumer accepts; transfer occurs when evt_valid_o and evt_ready_i are both 1.
REQ-010 Port evt_id_o  output  3  index of the key whose press is offered; upper unused bits 0.
REQ-011 Port evt_ovf_o  output  N_KEYS  sticky per-key overflow flags.
REQ-012 Port ovf_clr_i  input  1  one-cycle pulse clearing all evt_ovf_o bits.

Function
REQ-013 Tick counter: counts 0..CLK_FREQ/TICK_HZ-1 then wraps to 0; tick_o = 1 exactly in the cycle the counter equals its maximum.
REQ-014 Pending register: one bit per key; bit k sets in the cycle after key_cap_i[k] = 1.
REQ-015 Pending bit k clears in the cycle after its event is transferred.
REQ-016 Capture and transfer of the same key in the same cycle: pending[k] ends at 1; no overflow.
REQ-017 Capture on key k while pending[k] = 1 and key k is not being transferred: press is dropped and evt_ovf_o[k] sets.
REQ-018 ovf_clr_i with a simultaneous new overflow on key k: evt_ovf_o[k] ends at 1; all other bits clear.
REQ-019 State machine, two states: IDLE (evt_valid_o = 0) and OFFER (evt_valid_o = 1).
REQ-020 IDLE -> OFFER when any pending bit is 1; evt_id_o loads the granted index in the same edge.
REQ-021 OFFER with evt_ready_i = 0: remain in OFFER; evt_id_o and evt_valid_o are held stable.
REQ-022 OFFER with transfer and other keys pending: remain in OFFER and load the next grant on the same edge, with no idle bubble.
REQ-023 OFFER with transfer and no other key pending: go to IDLE.
REQ-024 Grant is round-robin: search starts at (last granted index + 1) mod N_KEYS; the pointer updates only on transfer; the pointer resets to N_KEYS-1, so key 0 wins first.
REQ-025 Latency: a capture pulse in cycle t with the block in IDLE gives evt_valid_o = 1 in cycle t+2 (pending in t+1, offer in t+2).
REQ-026 A key already offered is never re-offered until its transfer completes; pending[k] may set again only after that.

Reset
REQ-027 rstn_i = 0 forces immediately: tick counter 0, tick_o 0, pending all 0, evt_valid_o 0, evt_id_o 0, evt_ovf_o all 0, state IDLE, RR pointer N_KEYS-1.
REQ-028 Reset during OFFER discards the offered event and all pending events; nothing is replayed after release.
REQ-029 First tick_o occurs CLK_FREQ/TICK_HZ cycles after reset release.

Structure
REQ-030 The shared package holds the state encoding (IDLE, OFFER), the derived tick period constant, and the evt_id width constant (3).
REQ-031 Tick generator is a separate sub-module key_tick_gen (CLK_FREQ, TICK_HZ -> tick_o); arbiter, pending and overflow logic stay in key_event_arb.
REQ-032 RTL target: 120-250 lines total, with no vendor primitives.

Verification
REQ-033 CLK_FREQ=1000, TICK_HZ=100: after reset release, tick_o pulses at cycles 10, 20, 30, each for 1 cycle.
REQ-034 key_cap_i=4'b0100 at t, evt_ready_i=1: evt_valid_o=1, evt_id_o=2 at t+2; returns to IDLE at t+3.
REQ-035 key_cap_i=4'b1111 in one cycle, evt_ready_i=1: ids 0,1,2,3 back-to-back on 4 consecutive cycles, evt_ovf_o=0.
REQ-036 evt_ready_i=0, key 1 offered, second key_cap_i[1] pulse -> evt_ovf_o=4'b0010; ovf_clr_i -> 4'b0000 next cycle.
REQ-037 rstn_i low for 1 cycle mid-OFFER with keys 0 and 3 pending -> evt_valid_o=0 immediately; no event after release until a new capture.
REQ-038 Keys 0 and 1 each re-captured after every transfer, ready held 1: grants alternate 0,1,0,1 (fairness).

Source files
------------

// File: rtl/key_event_arb_pkg.sv
// Shared definitions for the key event arbiter: FSM encoding, event id
// width and the tick period derivation used by the tick generator.
package key_event_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam int EVT_ID_W     = 3;
  localparam int DEF_CLK_FREQ = 100000000;
  localparam int DEF_TICK_HZ  = 100;

  // Clock cycles between debounce strobes; never below one cycle.
  function automatic int tick_period(input int clk_freq, input int tick_hz);
    int p;
    p = clk_freq / tick_hz;
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/key_event_arb_tick.sv
// Shared debounce strobe: a wrapping counter whose terminal value is the tick.
module key_tick_gen
  import key_event_arb_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int TICK_HZ  = DEF_TICK_HZ
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic tick_o
);

  localparam int PERIOD = tick_period(CLK_FREQ, TICK_HZ);
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);
  assign tick_o   = w_at_max;

  // Count 0..PERIOD-1 and wrap; the strobe is the cycle spent at the top.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (w_at_max) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_arb.sv
// Collects debounced key presses into a pending set and offers them one at a
// time over a valid/ready handshake, round-robin, with sticky overflow flags.
//
//   state    | meaning
//   ST_IDLE  | nothing offered, waiting for a pending key
//   ST_OFFER | evt_id_o is offered, held until the consumer takes it
module key_event_arb
  import key_event_arb_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int TICK_HZ  = DEF_TICK_HZ,
  parameter int N_KEYS   = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [N_KEYS-1:0]   key_cap_i,
  output logic                tick_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [EVT_ID_W-1:0] evt_id_o,
  output logic [N_KEYS-1:0]   evt_ovf_o,
  input  logic                ovf_clr_i
);

  localparam logic [EVT_ID_W-1:0] LAST_IDX = EVT_ID_W'(N_KEYS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_KEYS-1:0]     r_pend;
  logic [N_KEYS-1:0]     r_ovf;
  logic [EVT_ID_W-1:0]   r_id;
  logic [EVT_ID_W-1:0]   r_ptr;
  logic [N_KEYS-1:0]     w_xfer_vec;
  logic [N_KEYS-1:0]     w_req;
  logic [N_KEYS-1:0]     w_new_ovf;
  logic [EVT_ID_W-1:0]   w_base;
  logic [EVT_ID_W-1:0]   w_grant;
  logic [EVT_ID_W-1:0]   w_grant_hi;
  logic [EVT_ID_W-1:0]   w_grant_lo;
  logic                  w_found_hi;
  logic                  w_any_req;
  logic                  w_xfer;
  logic                  w_load;

  key_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .tick_o (tick_o)
  );

  assign w_xfer = (r_state == ST_OFFER) && evt_ready_i;

  // One-hot of the key leaving this cycle (all zero when nothing transfers).
  always_comb begin
    w_xfer_vec = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      w_xfer_vec[k] = w_xfer && (r_id == EVT_ID_W'(k));
    end
  end

  // The key being transferred is excluded so it is never offered twice.
  assign w_req     = r_pend & ~w_xfer_vec;
  assign w_any_req = |w_req;
  // On a transfer the pointer moves to the current id this same edge, so the
  // search for the follow-on grant already starts after it.
  assign w_base    = w_xfer ? r_id : r_ptr;

  // Round-robin: lowest requester above the base wins, else lowest overall.
  always_comb begin
    w_grant_hi = '0;
    w_grant_lo = '0;
    w_found_hi = 1'b0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (w_req[k]) begin
        if (EVT_ID_W'(k) > w_base) begin
          w_grant_hi = EVT_ID_W'(k);
          w_found_hi = 1'b1;
        end else begin
          w_grant_lo = EVT_ID_W'(k);
        end
      end
    end
    w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
  end

  // Next-state decode; w_load marks edges where a new grant is latched.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_OFFER;
          w_load      = 1'b1;
        end
      end
      ST_OFFER: begin
        if (evt_ready_i) begin
          if (w_any_req) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Offered id and round-robin pointer; the pointer only moves on transfer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_id  <= '0;
      r_ptr <= LAST_IDX;
    end else begin
      if (w_load) begin
        r_id <= w_grant;
      end
      if (w_xfer) begin
        r_ptr <= r_id;
      end
    end
  end

  // A press on an already pending key that is not leaving is dropped.
  assign w_new_ovf = key_cap_i & r_pend & ~w_xfer_vec;

  // Pending set: capture wins over a same-cycle transfer of the same key.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_xfer_vec) | key_cap_i;
    end
  end

  // Sticky overflow flags; a new overflow survives a simultaneous clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (ovf_clr_i ? '0 : r_ovf) | w_new_ovf;
    end
  end

  assign evt_valid_o = (r_state == ST_OFFER);
  assign evt_id_o    = r_id;
  assign evt_ovf_o   = r_ovf;

endmodule
